// File: rtl/stopwatch_counter_if.sv
// rtl/stopwatch_counter_if.sv - command input and BCD time/status outputs of the stopwatch core
interface stopwatch_counter_if;
    logic [2:0] state;
    logic [3:0] cs_ones;
    logic [3:0] cs_tens;
    logic [3:0] sec_ones;
    logic [3:0] sec_tens;
    logic [3:0] min_ones;
    logic [3:0] min_tens;
    logic [1:0] mode;
    logic       running;
    logic       overflow;

    modport master (
        output state,
        input  cs_ones, cs_tens, sec_ones, sec_tens, min_ones, min_tens,
        input  mode, running, overflow
    );

    modport slave (
        input  state,
        output cs_ones, cs_tens, sec_ones, sec_tens, min_ones, min_tens,
        output mode, running, overflow
    );
endinterface

// File: rtl/stopwatch_counter.sv
// rtl/stopwatch_counter.sv - command FSM, centisecond prescaler and MM:SS.CC BCD counter
module stopwatch_counter #(
    parameter int CLK_HZ  = 50_000_000,
    parameter int TICK_HZ = 100
) (
    input  logic               clk,
    input  logic               rst_n,
    stopwatch_counter_if.slave sw
);
    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = (DIV > 2) ? $clog2(DIV) : 1;

    localparam logic [2:0] CMD_RESET = 3'b001;
    localparam logic [2:0] CMD_COUNT = 3'b010;
    localparam logic [2:0] CMD_PAUSE = 3'b011;
    localparam logic [2:0] CMD_STOP  = 3'b100;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSED  = 2'd2,
        STOPPED = 2'd3
    } mode_t;

    mode_t curMode;
    mode_t nextMode;

    logic [PW-1:0] prescaler;
    logic [3:0]    csOnes, csTens, secOnes, secTens, minOnes, minTens;
    logic          tick;
    logic          carryCsTens, carrySecOnes, carrySecTens, carryMinOnes, carryMinTens, wrap;

    function automatic logic [3:0] bcdNext(input logic [3:0] d, input logic [3:0] top);
        return (d == top) ? 4'd0 : d + 4'd1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) curMode <= IDLE;
        else        curMode <= nextMode;
    end

    always_comb begin
        nextMode = curMode;
        case (sw.state)
            CMD_RESET: nextMode = IDLE;
            CMD_COUNT: if (curMode == IDLE || curMode == PAUSED) nextMode = RUN;
            CMD_PAUSE: if (curMode == RUN) nextMode = PAUSED;
            CMD_STOP:  if (curMode == RUN || curMode == PAUSED) nextMode = STOPPED;
            default:   nextMode = curMode;
        endcase
    end

    // Advancement is gated by the pre-edge mode, so the PAUSE/STOP edge still counts.
    assign tick         = (curMode == RUN) && (prescaler == PW'(DIV - 1));
    assign carryCsTens  = tick         && (csOnes  == 4'd9);
    assign carrySecOnes = carryCsTens  && (csTens  == 4'd9);
    assign carrySecTens = carrySecOnes && (secOnes == 4'd9);
    assign carryMinOnes = carrySecTens && (secTens == 4'd5);
    assign carryMinTens = carryMinOnes && (minOnes == 4'd9);
    assign wrap         = carryMinTens && (minTens == 4'd9);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler    <= '0;
            csOnes       <= 4'd0;
            csTens       <= 4'd0;
            secOnes      <= 4'd0;
            secTens      <= 4'd0;
            minOnes      <= 4'd0;
            minTens      <= 4'd0;
            sw.overflow  <= 1'b0;
        end else if (sw.state == CMD_RESET) begin
            prescaler    <= '0;
            csOnes       <= 4'd0;
            csTens       <= 4'd0;
            secOnes      <= 4'd0;
            secTens      <= 4'd0;
            minOnes      <= 4'd0;
            minTens      <= 4'd0;
            sw.overflow  <= 1'b0;
        end else if (curMode == RUN) begin
            prescaler <= tick ? '0 : prescaler + PW'(1);
            if (tick)         csOnes  <= bcdNext(csOnes, 4'd9);
            if (carryCsTens)  csTens  <= bcdNext(csTens, 4'd9);
            if (carrySecOnes) secOnes <= bcdNext(secOnes, 4'd9);
            if (carrySecTens) secTens <= bcdNext(secTens, 4'd5);
            if (carryMinOnes) minOnes <= bcdNext(minOnes, 4'd9);
            if (carryMinTens) minTens <= bcdNext(minTens, 4'd9);
            if (wrap)         sw.overflow <= 1'b1;
        end
    end

    assign sw.cs_ones  = csOnes;
    assign sw.cs_tens  = csTens;
    assign sw.sec_ones = secOnes;
    assign sw.sec_tens = secTens;
    assign sw.min_ones = minOnes;
    assign sw.min_tens = minTens;
    assign sw.mode     = curMode;
    assign sw.running  = (curMode == RUN);
endmodule
